// File: rtl/intrapred_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intrapred_pkg
// Description : Shared types for the intra mode decision path: prediction
//               mode encodings, decider FSM states and SAD width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package intrapred_pkg;

  // Luma 4x4 prediction modes
  typedef enum logic [3:0] {
    L4_V   = 4'd0,
    L4_H   = 4'd1,
    L4_DC  = 4'd2,
    L4_DDL = 4'd3,
    L4_DDR = 4'd4,
    L4_VR  = 4'd5,
    L4_HD  = 4'd6,
    L4_VL  = 4'd7,
    L4_HU  = 4'd8
  } luma4x4_mode_e;

  // Luma 16x16 and chroma 8x8 prediction modes
  typedef enum logic [1:0] {
    L16_V     = 2'd0,
    L16_H     = 2'd1,
    L16_DC    = 2'd2,
    L16_PLANE = 2'd3
  } luma16_mode_e;

  // Decider control states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_COMPARE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  // Width that holds the worst-case SAD (255 per pixel) of a w x h block
  function automatic int sad_width(input int w, input int h);
    return 8 + $clog2(w * h);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sad_lane.sv
`default_nettype none
// ============================================================================
// Module      : sad_lane
// Description : One prediction mode's SAD path: PPC absolute differences,
//               per-beat sum and a clearable running accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module sad_lane #(
  parameter int PPC   = 4,
  parameter int SAD_W = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               en_i,
  input  logic [PPC*8-1:0]   org_pix_i,
  input  logic [PPC*8-1:0]   pred_pix_i,
  output logic [SAD_W-1:0]   acc_o
);

  logic [7:0]       diff [PPC];
  logic [SAD_W-1:0] beat_sum;
  logic [SAD_W-1:0] acc_d;
  logic [SAD_W-1:0] acc_q;

  // Unsigned 8-bit absolute difference per pixel
  for (genvar k = 0; k < PPC; k++) begin : g_absdiff
    logic [7:0] o_px;
    logic [7:0] p_px;
    assign o_px    = org_pix_i[k*8 +: 8];
    assign p_px    = pred_pix_i[k*8 +: 8];
    assign diff[k] = (o_px >= p_px) ? (o_px - p_px) : (p_px - o_px);
  end

  // Sum of this beat's differences; SAD_W always covers PPC*255
  always_comb begin
    beat_sum = '0;
    for (int k = 0; k < PPC; k++) begin
      beat_sum = beat_sum + {{(SAD_W-8){1'b0}}, diff[k]};
    end
  end

  // Next accumulator value: clear wins, otherwise add on enabled beats
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + beat_sum;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/intra_mode_decider.sv
`default_nettype none
// ============================================================================
// Module      : intra_mode_decider
// Description : Streams one block of original pixels plus NUM_MODES
//               predictions, accumulates a SAD per mode, then scans the
//               enabled modes one per cycle and reports the minimum.
// Revision    : 1.0 - initial release
// ============================================================================
module intra_mode_decider
  import intrapred_pkg::*;
#(
  parameter  int BLK_W     = 4,
  parameter  int BLK_H     = 4,
  parameter  int NUM_MODES = 9,
  parameter  int PPC       = 4,
  localparam int SAD_W     = sad_width(BLK_W, BLK_H),
  localparam int MODE_W    = $clog2(NUM_MODES)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NUM_MODES-1:0]       mode_mask,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PPC*8-1:0]           org_pix,
  input  logic [NUM_MODES*PPC*8-1:0] pred_pix,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [MODE_W-1:0]          best_mode,
  output logic [SAD_W-1:0]           best_sad,
  output logic                       no_mode,
  output logic                       busy
);

  localparam int BEATS = (BLK_W * BLK_H) / PPC;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [MODE_W-1:0] LAST_MODE = MODE_W'(NUM_MODES - 1);

  state_e                 state_q;
  logic [NUM_MODES-1:0]   mask_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [MODE_W-1:0]      cmp_idx_q;
  logic                   found_q;
  logic [MODE_W-1:0]      best_mode_q;
  logic [SAD_W-1:0]       best_sad_q;
  logic                   no_mode_q;
  logic                   out_valid_q;
  logic                   in_ready_q;
  logic                   busy_q;

  logic                   lane_clr;
  logic                   beat_fire;
  logic [SAD_W-1:0]       acc [NUM_MODES];
  logic [SAD_W-1:0]       cur_acc;

  assign lane_clr  = (state_q == ST_IDLE) && start;
  assign beat_fire = (state_q == ST_ACCUM) && in_valid && in_ready_q;
  assign cur_acc   = acc[cmp_idx_q];

  // One SAD lane per candidate mode
  for (genvar m = 0; m < NUM_MODES; m++) begin : g_lane
    sad_lane #(
      .PPC   (PPC),
      .SAD_W (SAD_W)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .clr_i      (lane_clr),
      .en_i       (beat_fire),
      .org_pix_i  (org_pix),
      .pred_pix_i (pred_pix[m*PPC*8 +: PPC*8]),
      .acc_o      (acc[m])
    );
  end

  // Control FSM: accumulate beats, scan modes, hold result until consumed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      beat_cnt_q  <= '0;
      cmp_idx_q   <= '0;
      found_q     <= 1'b0;
      best_mode_q <= '0;
      best_sad_q  <= '0;
      no_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q      <= mode_mask;
            beat_cnt_q  <= '0;
            cmp_idx_q   <= '0;
            found_q     <= 1'b0;
            // All-ones doubles as the reported SAD when no mode is enabled
            best_mode_q <= '0;
            best_sad_q  <= '1;
            no_mode_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (beat_fire) begin
            if (beat_cnt_q == LAST_BEAT) begin
              in_ready_q <= 1'b0;
              state_q    <= ST_COMPARE;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        ST_COMPARE: begin
          // Strict less-than keeps the lowest index on ties
          if (mask_q[cmp_idx_q] && (!found_q || (cur_acc < best_sad_q))) begin
            best_sad_q  <= cur_acc;
            best_mode_q <= cmp_idx_q;
            found_q     <= 1'b1;
          end
          if (cmp_idx_q == LAST_MODE) begin
            no_mode_q   <= ~|mask_q;
            out_valid_q <= 1'b1;
            state_q     <= ST_OUTPUT;
          end else begin
            cmp_idx_q <= cmp_idx_q + MODE_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign best_mode = best_mode_q;
  assign best_sad  = best_sad_q;
  assign no_mode   = no_mode_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_intra_mode_decider.sv
`default_nettype none
// ============================================================================
// Module      : tb_intra_mode_decider
// Description : Directed self-checking bench for a 4x4/9-mode decider and a
//               16x16/4-mode decider sharing one clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intra_mode_decider;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // 4x4, 9 modes, 4 pixels per beat: SAD_W=12, MODE_W=4, 4 beats
  logic         a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic         a_no_mode, a_busy;
  logic [8:0]   a_mask;
  logic [31:0]  a_org;
  logic [287:0] a_pred;
  logic [3:0]   a_best_mode;
  logic [11:0]  a_best_sad;

  // 16x16, 4 modes, 16 pixels per beat: SAD_W=16, MODE_W=2, 16 beats
  logic         b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic         b_no_mode, b_busy;
  logic [3:0]   b_mask;
  logic [127:0] b_org;
  logic [511:0] b_pred;
  logic [1:0]   b_best_mode;
  logic [15:0]  b_best_sad;

  int errors = 0;
  int checks = 0;

  logic [7:0] pred_tab [9][4];
  logic [7:0] org_v;

  intra_mode_decider #(.BLK_W(4), .BLK_H(4), .NUM_MODES(9), .PPC(4)) u_dut_a (
    .clk(clk), .reset(reset), .start(a_start), .mode_mask(a_mask),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .org_pix(a_org),
    .pred_pix(a_pred), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .best_mode(a_best_mode), .best_sad(a_best_sad), .no_mode(a_no_mode),
    .busy(a_busy)
  );

  intra_mode_decider #(.BLK_W(16), .BLK_H(16), .NUM_MODES(4), .PPC(16)) u_dut_b (
    .clk(clk), .reset(reset), .start(b_start), .mode_mask(b_mask),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .org_pix(b_org),
    .pred_pix(b_pred), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .best_mode(b_best_mode), .best_sad(b_best_sad), .no_mode(b_no_mode),
    .busy(b_busy)
  );

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic fill_all(input logic [7:0] v);
    for (int m = 0; m < 9; m++)
      for (int k = 0; k < 4; k++)
        pred_tab[m][k] = v;
  endtask

  task automatic fill_mode(input int m, input logic [7:0] p0, input logic [7:0] p1,
                           input logic [7:0] p2, input logic [7:0] p3);
    pred_tab[m][0] = p0; pred_tab[m][1] = p1;
    pred_tab[m][2] = p2; pred_tab[m][3] = p3;
  endtask

  task automatic pack_a();
    for (int m = 0; m < 9; m++)
      for (int k = 0; k < 4; k++)
        a_pred[(m*4+k)*8 +: 8] = pred_tab[m][k];
    for (int k = 0; k < 4; k++)
      a_org[k*8 +: 8] = org_v;
  endtask

  task automatic start_a(input logic [8:0] mask);
    @(posedge clk); #1;
    a_start = 1'b1;
    a_mask  = mask;
    @(posedge clk); #1;
    a_start = 1'b0;
  endtask

  // Feeds nbeats identical beats (optionally toggling in_valid); when
  // wait_out is set, returns the number of rising edges from the last
  // accepted beat until out_valid is seen (capped at 50).
  task automatic feed_a(input bit stall, input int nbeats, input bit wait_out,
                        output int lat);
    int   b;
    int   g;
    logic fire;
    b = 0; g = 0; lat = 0;
    pack_a();
    while (b < nbeats && g < 200) begin
      a_in_valid = stall ? ((g % 2) == 0) : 1'b1;
      @(negedge clk);
      fire = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (fire) b++;
      g++;
    end
    a_in_valid = 1'b0;
    if (wait_out) begin
      while (lat < 50) begin
        @(negedge clk);
        if (a_out_valid) break;
        @(posedge clk); #1;
        lat++;
      end
    end
  endtask

  task automatic handshake_a();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  // Pattern: mode0 SAD 0 (disabled by mask), mode2 SAD 8, others SAD 40
  task automatic load_mask_pattern();
    org_v = 8'd100;
    for (int m = 0; m < 9; m++) fill_mode(m, 8'd102, 8'd102, 8'd103, 8'd103);
    fill_mode(0, 8'd100, 8'd100, 8'd100, 8'd100);
    fill_mode(2, 8'd101, 8'd100, 8'd101, 8'd100);
  endtask

  // Pattern: modes 1 and 5 SAD 16, others SAD 160
  task automatic load_tie_pattern();
    org_v = 8'd100;
    fill_all(8'd90);
    fill_mode(1, 8'd101, 8'd101, 8'd101, 8'd101);
    fill_mode(5, 8'd99, 8'd99, 8'd99, 8'd99);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", a_in_ready); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    checks++; if (a_best_sad !== 12'd0 || a_best_mode !== 4'd0 || a_no_mode !== 1'b0) begin
      errors++; $display("FAIL reset_result: got mode=%0d sad=%0d no_mode=%b want 0/0/0", a_best_mode, a_best_sad, a_no_mode); end
    checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0 || b_best_sad !== 16'd0) begin
      errors++; $display("FAIL reset_b: got ov=%b busy=%b sad=%0d want 0/0/0", b_out_valid, b_busy, b_best_sad); end
  endtask

  task automatic test_exact();
    int lat;
    org_v = 8'd100;
    fill_all(8'd90);
    fill_mode(3, 8'd100, 8'd100, 8'd100, 8'd100);
    start_a(9'h1FF);
    checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL exact_accum: got busy=%b in_ready=%b want 1/1", a_busy, a_in_ready); end
    feed_a(1'b0, 4, 1'b1, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL exact_latency: got %0d edges want 9", lat); end
    checks++; if (a_best_mode !== 4'd3) begin errors++; $display("FAIL exact_mode: got %0d want 3", a_best_mode); end
    checks++; if (a_best_sad !== 12'd0) begin errors++; $display("FAIL exact_sad: got %0d want 0", a_best_sad); end
    checks++; if (a_no_mode !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++; $display("FAIL exact_flags: got no_mode=%b in_ready=%b want 0/0", a_no_mode, a_in_ready); end
    handshake_a();
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL exact_release: got ov=%b busy=%b want 0/0", a_out_valid, a_busy); end
  endtask

  task automatic test_tie();
    int lat;
    load_tie_pattern();
    start_a(9'h1FF);
    feed_a(1'b0, 4, 1'b1, lat);
    checks++; if (a_best_mode !== 4'd1) begin errors++; $display("FAIL tie_mode: got %0d want 1", a_best_mode); end
    checks++; if (a_best_sad !== 12'd16) begin errors++; $display("FAIL tie_sad: got %0d want 16", a_best_sad); end
    handshake_a();
  endtask

  task automatic test_mask();
    int lat;
    load_mask_pattern();
    start_a(9'h1FE);
    feed_a(1'b0, 4, 1'b1, lat);
    checks++; if (a_best_mode !== 4'd2 || a_best_sad !== 12'd8) begin
      errors++; $display("FAIL mask_skip: got mode=%0d sad=%0d want 2/8", a_best_mode, a_best_sad); end
    handshake_a();
  endtask

  task automatic test_16x16();
    int   b;
    int   g;
    int   lat;
    logic fire;
    for (int k = 0; k < 16; k++) b_org[k*8 +: 8] = 8'd255;
    for (int m = 0; m < 4; m++)
      for (int k = 0; k < 16; k++)
        b_pred[(m*16+k)*8 +: 8] = (m == 0) ? 8'd0 : 8'd128;
    @(posedge clk); #1;
    b_start = 1'b1; b_mask = 4'hF;
    @(posedge clk); #1;
    b_start = 1'b0;
    b = 0; g = 0; lat = 0;
    while (b < 16 && g < 100) begin
      b_in_valid = 1'b1;
      @(negedge clk);
      fire = b_in_ready;
      @(posedge clk); #1;
      if (fire) b++;
      g++;
    end
    b_in_valid = 1'b0;
    while (lat < 50) begin
      @(negedge clk);
      if (b_out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL b_latency: got %0d edges want 4", lat); end
    checks++; if (b_best_mode !== 2'd1) begin errors++; $display("FAIL b_mode: got %0d want 1", b_best_mode); end
    checks++; if (b_best_sad !== 16'd32512 || b_no_mode !== 1'b0) begin
      errors++; $display("FAIL b_sad: got sad=%0d no_mode=%b want 32512/0", b_best_sad, b_no_mode); end
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic test_zero_mask_stall();
    int lat;
    load_tie_pattern();
    start_a(9'h000);
    feed_a(1'b1, 4, 1'b1, lat);
    checks++; if (a_no_mode !== 1'b1) begin errors++; $display("FAIL zero_no_mode: got %b want 1", a_no_mode); end
    checks++; if (a_best_mode !== 4'd0 || a_best_sad !== 12'hFFF) begin
      errors++; $display("FAIL zero_result: got mode=%0d sad=%h want 0/fff", a_best_mode, a_best_sad); end
    handshake_a();
    start_a(9'h1FF);
    feed_a(1'b1, 4, 1'b1, lat);
    checks++; if (lat !== 9) begin errors++; $display("FAIL stall_latency: got %0d edges want 9", lat); end
    checks++; if (a_best_mode !== 4'd1 || a_best_sad !== 12'd16 || a_no_mode !== 1'b0) begin
      errors++; $display("FAIL stall_result: got mode=%0d sad=%0d no_mode=%b want 1/16/0", a_best_mode, a_best_sad, a_no_mode); end
    handshake_a();
  endtask

  task automatic test_hold_back_to_back();
    int lat;
    org_v = 8'd100;
    fill_all(8'd90);
    fill_mode(3, 8'd100, 8'd100, 8'd100, 8'd100);
    start_a(9'h1FF);
    feed_a(1'b0, 4, 1'b1, lat);
    // start raised while results are held must not disturb them
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      a_start = 1'b1;
      a_mask  = 9'h1FE;
      @(negedge clk);
      checks++; if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0 || a_best_mode !== 4'd3 || a_best_sad !== 12'd0) begin
        errors++; $display("FAIL hold_c%0d: got ov=%b rdy=%b mode=%0d sad=%0d want 1/0/3/0", c, a_out_valid, a_in_ready, a_best_mode, a_best_sad); end
    end
    load_mask_pattern();
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b ov=%b want 0/0", a_busy, a_out_valid); end
    @(posedge clk); #1;
    a_start = 1'b0;
    @(negedge clk);
    checks++; if (a_busy !== 1'b1 || a_in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_start: got busy=%b rdy=%b want 1/1", a_busy, a_in_ready); end
    @(posedge clk); #1;
    feed_a(1'b0, 4, 1'b1, lat);
    checks++; if (a_best_mode !== 4'd2 || a_best_sad !== 12'd8) begin
      errors++; $display("FAIL b2b_result: got mode=%0d sad=%0d want 2/8", a_best_mode, a_best_sad); end
    handshake_a();
  endtask

  task automatic test_reset_mid();
    int lat;
    load_tie_pattern();
    start_a(9'h1FF);
    feed_a(1'b0, 2, 1'b0, lat);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_async: got busy=%b ov=%b rdy=%b want 0/0/0", a_busy, a_out_valid, a_in_ready); end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
      errors++; $display("FAIL midreset_no_output: got ov=%b busy=%b want 0/0", a_out_valid, a_busy); end
    load_mask_pattern();
    start_a(9'h1FE);
    feed_a(1'b0, 4, 1'b1, lat);
    checks++; if (lat !== 9 || a_best_mode !== 4'd2 || a_best_sad !== 12'd8) begin
      errors++; $display("FAIL midreset_next: got lat=%0d mode=%0d sad=%0d want 9/2/8", lat, a_best_mode, a_best_sad); end
    handshake_a();
  endtask

  initial begin
    reset = 1'b0;
    a_start = 1'b0; a_mask = '0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    a_org = '0; a_pred = '0;
    b_start = 1'b0; b_mask = '0; b_in_valid = 1'b0; b_out_ready = 1'b0;
    b_org = '0; b_pred = '0;
    org_v = '0;
    fill_all(8'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    test_reset();
    test_exact();
    test_tie();
    test_mask();
    test_16x16();
    test_zero_mask_stall();
    test_hold_back_to_back();
    test_reset_mid();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/intra_mode_decider.md
Name: intra_mode_decider

Overview:
- Parametrised, streaming successor to the fixed-size intra SAD/decision path. Accepts one block of original pixels plus NUM_MODES candidate predictions, PPC pixels per beat, over a valid/ready handshake.
- Accumulates one SAD per mode, skips modes disabled by a per-block availability mask, and returns the best mode and its SAD over an output handshake.
- One instance serves luma 4x4, luma 16x16 or chroma 8x8 by parameter choice.
- Sits between the moder_* prediction generators and the saver_* residual store.

Parameters:
- BLK_W, 4, block width in pixels (4, 8 or 16).
- BLK_H, 4, block height in pixels (4, 8 or 16).
- NUM_MODES, 9, candidate modes per block (2..16).
- PPC, 4, pixels per beat; BLK_W*BLK_H must be a multiple of PPC.
- Derived localparams:
  - BEATS = BLK_W*BLK_H/PPC
  - SAD_W = 8 + $clog2(BLK_W*BLK_H)
  - MODE_W = $clog2(NUM_MODES)

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin a block; sampled only in IDLE.
- mode_mask  in  NUM_MODES  bit m=1 means mode m is available; captured on accepted start.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid&in_ready.
- org_pix  in  PPC*8  original pixels; pixel k at bits [8k+7:8k].
- pred_pix  in  NUM_MODES*PPC*8  predictions; mode m, pixel k at bits [(m*PPC+k)*8 +: 8].
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid&out_ready.
- best_mode  out  MODE_W  index of the minimum-SAD enabled mode.
- best_sad  out  SAD_W  SAD of best_mode.
- no_mode  out  1  mask was all-zero; best_mode/best_sad are meaningless.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; accumulators, beat counter and compare registers cleared.
- FSM states: IDLE, ACCUM, COMPARE, OUTPUT.
- IDLE:
  - in_ready=0.
  - start=1 → capture mask, clear accumulators and beat_cnt → ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat: acc[m] += sum over k of |org_k - pred_m,k| (8-bit unsigned abs diff, widened to SAD_W; never saturates).
  - beat_cnt increments per accepted beat; in_valid=0 stalls with no state change.
  - Accepting beat BEATS-1 → COMPARE (in_ready drops the next cycle).
- COMPARE:
  - One mode per cycle, m = 0..NUM_MODES-1, so NUM_MODES cycles total.
  - A mode with mask=0 is skipped (cycle still consumed).
  - The first enabled mode loads best; a later mode replaces best only if acc[m] < best (strict), so ties resolve to the lowest index.
  - After the last mode → OUTPUT.
- OUTPUT:
  - out_valid=1; best_mode, best_sad, no_mode held stable until out_ready=1.
  - Handshake → IDLE; out_valid=0 the next cycle.
- Latency: the cycle after the final accepted beat, COMPARE runs NUM_MODES cycles; out_valid rises on cycle NUM_MODES+1 after the last beat.
- Back-to-back: start asserted during the same cycle OUTPUT handshakes is ignored; it is accepted once the block is in IDLE, so there is a minimum of 1 IDLE cycle per block.
- start outside IDLE: ignored, no effect.
- All-zero mask: no_mode=1, best_mode=0, best_sad={SAD_W{1'b1}}.
- out_ready held low: results hold indefinitely; in_ready stays 0 (no input buffering).
- Reset mid-block: the partial block is discarded and no output is produced.
- pred_pix for masked modes is don't-care.

Decomposition:
- intrapred_pkg holds:
  - enum of luma4x4 modes: V=0, H=1, DC=2, DDL=3, DDR=4, VR=5, HD=6, VL=7, HU=8.
  - enum of 16x16/chroma modes: V=0, H=1, DC=2, PLANE=3.
  - FSM state typedef.
  - function sad_width(w, h).
- Sub-module sad_lane (params PPC, SAD_W):
  - PPC abs-diff units, adder tree, SAD_W accumulator with clear/enable.
  - Instantiated NUM_MODES times with a generate loop.

Test Plan:
- 4x4 (PPC=4, 9 modes, mask=9'h1FF): org all 100; mode3 pred all 100, others all 90 → best_mode=3, best_sad=0, out_valid on cycle 10 after the 4th beat.
- Tie case: modes 1 and 5 both SAD=16, all others higher → best_mode=1, best_sad=16.
- Mask 9'h1FE, mode0 SAD=0, mode2 SAD=8, all others 40 → best_mode=2, best_sad=8.
- 16x16 (PPC=16, 4 modes): org=255, pred mode0=0, others=128 → mode0 SAD=65280 fits 16 bits; best_mode=1, best_sad=32512.
- mask=0 → no_mode=1, best_sad=16'hFFFF (4x4: 12'hFFF); in_valid toggled 1/0 each cycle → same result as an unstalled run.
- out_ready held low 20 cycles → outputs stable, in_ready=0.
- reset pulsed low mid-ACCUM → busy=0 and out_valid=0 immediately; the next block's result is correct.
